irq_ctrl: RTL

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl
// Purpose  : Small vectored interrupt controller. Collects up to 8 interrupt
//            lines and marks each one as edge or level triggered. It masks
//            them and raises a single request to the CPU. The lowest-index
//            active source has priority. There is no nesting: once a source
//            is acknowledged, no new request is raised until software writes
//            EOI.
// Ports    : clk      - system clock; all state changes on the rising edge
//            reset    - asynchronous active-low reset
//            irq_in   - interrupt lines from peripherals (bit 0 = Timer0)
//            Addr     - bus word address; only Addr[3:2] is decoded
//            WE       - single-cycle bus write enable
//            Din      - bus write data
//            Dout     - bus read data, combinational from Addr[3:2]
//            int_req  - registered interrupt request to the CPU
//            int_ack  - single-cycle CPU acknowledge
//            int_id   - registered ID of the acknowledged source
// Register map (word index = Addr[3:2]):
//            0 PENDING (R, write-1-to-clear edge bits)
//            1 MASK    (RW)
//            2 CUR     (R: [2:0]=int_id, [8]=in_service; any write = EOI)
//            3 EDGE    (RW: 1=edge, 0=level)
// Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
  parameter int N_SRC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [31:0]      Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  output logic             int_req,
  input  logic             int_ack,
  output logic [2:0]       int_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] pending_nxt;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] edge_cfg;
  logic [N_SRC-1:0] irq_prev;
  logic [N_SRC-1:0] active;
  logic [2:0]       winner;

  logic [1:0]       sel;
  logic             wr_pend;
  logic             wr_mask;
  logic             wr_cur;
  logic             wr_edge;
  logic             ack_take;

  // Address bits outside [3:2] and data bits above the source count are
  // intentionally ignored.
  logic             unused_bits;
  assign unused_bits = &{1'b0, Addr[31:4], Addr[1:0], Din[31:N_SRC]};

  assign sel      = Addr[3:2];
  assign wr_pend  = WE && (sel == 2'd0);
  assign wr_mask  = WE && (sel == 2'd1);
  assign wr_cur   = WE && (sel == 2'd2);
  assign wr_edge  = WE && (sel == 2'd3);
  assign active   = pending & mask;
  assign ack_take = (state == REQ) && int_ack;

  // Priority encoder: scan from the top so the lowest set index wins.
  always_comb begin
    winner = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) winner = 3'(i);
    end
  end

  // Edge bits are sticky. A new rising edge beats a same-cycle W1C or ack
  // clear, so an event is never lost. Level bits simply follow the line, so
  // W1C and ack have no effect on them.
  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < N_SRC; i++) begin
      if (edge_cfg[i]) begin
        if (irq_in[i] && !irq_prev[i]) begin
          pending_nxt[i] = 1'b1;
        end else if ((wr_pend && Din[i]) ||
                     (ack_take && active[i] && (winner == 3'(i)))) begin
          pending_nxt[i] = 1'b0;
        end
      end else begin
        pending_nxt[i] = irq_in[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending  <= '0;
      mask     <= '0;
      edge_cfg <= '0;
      irq_prev <= '0;
    end else begin
      pending  <= pending_nxt;
      irq_prev <= irq_in;
      if (wr_mask) mask     <= Din[N_SRC-1:0];
      if (wr_edge) edge_cfg <= Din[N_SRC-1:0];
    end
  end

  // Request sequencing.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (|active) state_nxt = REQ;
      end
      REQ: begin
        if (int_ack)       state_nxt = SERVICE;
        else if (~|active) state_nxt = IDLE;   // request withdrawn
      end
      SERVICE: begin
        if (wr_cur) state_nxt = IDLE;          // EOI
      end
      default: state_nxt = IDLE;
    endcase
  end

  // int_req is a flop that tracks the next state. It is therefore high
  // exactly while the FSM sits in REQ, without a combinational path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      int_req <= 1'b0;
      int_id  <= 3'd0;
    end else begin
      state   <= state_nxt;
      int_req <= (state_nxt == REQ);
      if (ack_take) int_id <= winner;
    end
  end

  always_comb begin
    Dout = 32'd0;
    case (sel)
      2'd0: Dout[N_SRC-1:0] = pending;
      2'd1: Dout[N_SRC-1:0] = mask;
      2'd2: begin
        Dout[2:0] = int_id;
        Dout[8]   = (state == SERVICE);
      end
      default: Dout[N_SRC-1:0] = edge_cfg;
    endcase
  end

endmodule
`default_nettype wire
